// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg : shared state encoding and PC step helpers for the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam int PC_STEP_WORD = 1;
  localparam int PC_STEP_BYTE = 4;

  function automatic bit pc_step_legal(input int step);
    return (step == PC_STEP_WORD) || (step == PC_STEP_BYTE);
  endfunction

  // Number of PC bits below the instruction-word index.
  function automatic int step_shift(input int step);
    return (step == PC_STEP_BYTE) ? 2 : 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_next_calc.sv
// ============================================================================
// pc_next_calc : next-PC selection (jump > branch > step) and fault detection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_next_calc
  import seq_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int IADDR_BITS = 6,
  parameter int PC_STEP    = 1
) (
  input  logic [XLEN-1:0] pc,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  output logic [XLEN-1:0] pc_next,
  output logic            misaligned,
  output logic            out_of_range
);

  localparam int S  = step_shift(PC_STEP);
  localparam int HI = IADDR_BITS + S;
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << S) - XLEN'(1);
  // Bits at or above HI address beyond the instruction memory.
  localparam logic [XLEN-1:0] RANGE_MASK =
      (HI >= XLEN) ? '0 : ~((XLEN'(1) << HI) - XLEN'(1));

  always_comb begin
    pc_next = pc + XLEN'(PC_STEP);
    if (jump_en)
      pc_next = jump_target;
    else if (branch_taken)
      pc_next = pc + branch_offset;
  end

  assign misaligned   = |(pc_next & ALIGN_MASK);
  assign out_of_range = |(pc_next & RANGE_MASK);

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer : PC owner, req/ack fetch, multi-cycle exec hold and commit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
  import seq_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter int          ILEN        = 32,
  parameter int          IADDR_BITS  = 6,
  parameter int          PC_STEP     = 1,
  parameter int          EXEC_CYCLES = 4,
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  imem_req,
  output logic [IADDR_BITS-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [ILEN-1:0]       imem_data,
  output logic [ILEN-1:0]       instr,
  output logic                  instr_valid,
  output logic                  commit,
  input  logic                  jump_en,
  input  logic [XLEN-1:0]       jump_target,
  input  logic                  branch_taken,
  input  logic [XLEN-1:0]       branch_offset,
  output logic [XLEN-1:0]       pc,
  output logic                  fault,
  output logic [CNT_W-1:0]      retired
);

  localparam int S  = step_shift(PC_STEP);
  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(EXEC_CYCLES - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] pc_next;
  logic            misaligned;
  logic            out_of_range;
  logic            last_cycle;

  pc_next_calc #(
    .XLEN       (XLEN),
    .IADDR_BITS (IADDR_BITS),
    .PC_STEP    (PC_STEP)
  ) u_pc_next (
    .pc            (pc),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_next       (pc_next),
    .misaligned    (misaligned),
    .out_of_range  (out_of_range)
  );

  // Strobes decode straight from state so the async reset drops them at once.
  assign last_cycle  = (state == S_EXEC) && (cnt == LAST_CNT);
  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_EXEC);
  assign commit      = last_cycle;
  assign fault       = (state == S_FAULT);
  assign imem_addr   = pc[IADDR_BITS+S-1:S];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= XLEN'(RESET_PC);
      instr   <= '0;
      cnt     <= '0;
      retired <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run)
            state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr <= imem_data;
            cnt   <= '0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (last_cycle) begin
            pc      <= pc_next;
            retired <= retired + CNT_W'(1);
            if (misaligned || out_of_range)
              state <= S_FAULT;
            else if (run)
              state <= S_FETCH;
            else
              state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_FAULT;
      endcase
    end
  end

endmodule

`default_nettype wire
